// File: rtl/tx_tos_marker.sv
// AXI-Stream TX pass-through: rewrites the IPv4 TOS byte of selected packets and counts packets.
// Optional macro TX_CSUM_FIX_EN: incremental IPv4 header checksum update on marked beats.
module tx_tos_marker #(
  parameter logic [7:0]  TOS_VAL = 8'h28,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [255:0]     s_tdata,
  input  logic             s_tvalid,
  input  logic             s_tlast,
  output logic             s_tready,
  output logic [255:0]     m_tdata,
  output logic             m_tvalid,
  output logic             m_tlast,
  input  logic             m_tready,
  input  logic             mark_en,
  output logic [CNT_W-1:0] tx_count,
  output logic [CNT_W-1:0] tx_pkt_count
);

  localparam int unsigned DATA_W = 256;

  logic              is_first;
  logic              accept_c;
  logic              mark_c;
  logic [DATA_W-1:0] beat_c;

  // Output register can take a new beat when empty or draining this cycle.
  assign s_tready = !m_tvalid || m_tready;
  assign accept_c = s_tvalid && s_tready;
  assign mark_c   = accept_c && is_first && mark_en &&
                    (s_tdata[103:96] == 8'h08) && (s_tdata[111:104] == 8'h00);

`ifdef TX_CSUM_FIX_EN
  // One's-complement 16-bit add with end-around carry.
  function automatic logic [15:0] oc_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + 16'(s[16]);
  endfunction

  logic [15:0] hc_c;
  logic [15:0] m_old_c;
  logic [15:0] m_new_c;
  logic [15:0] hc_new_c;

  assign hc_c     = {s_tdata[199:192], s_tdata[207:200]};
  assign m_old_c  = {s_tdata[119:112], s_tdata[127:120]};
  assign m_new_c  = {s_tdata[119:112], TOS_VAL};
  assign hc_new_c = ~oc_add(oc_add(~hc_c, ~m_old_c), m_new_c);
`endif

  // Beat as it should leave the block.
  always_comb begin
    beat_c = s_tdata;
    if (mark_c) begin
      beat_c[127:120] = TOS_VAL;
`ifdef TX_CSUM_FIX_EN
      beat_c[199:192] = hc_new_c[15:8];
      beat_c[207:200] = hc_new_c[7:0];
`endif
    end
  end

  // Output pipeline stage; data held while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_tvalid <= 1'b0;
      m_tdata  <= '0;
      m_tlast  <= 1'b0;
    end else if (accept_c) begin
      m_tvalid <= 1'b1;
      m_tdata  <= beat_c;
      m_tlast  <= s_tlast;
    end else if (m_tready) begin
      m_tvalid <= 1'b0;
    end
  end

  // Packet boundary tracking and counters, updated on input accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      is_first     <= 1'b1;
      tx_count     <= '0;
      tx_pkt_count <= '0;
    end else if (accept_c) begin
      is_first <= s_tlast;
      if (is_first) begin
        tx_pkt_count <= tx_pkt_count + CNT_W'(1);
      end
      if (mark_c) begin
        tx_count <= tx_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_tx_tos_marker.sv
// Self-checking bench for tx_tos_marker: directed table, corner sequences, and randomized
// traffic against a packet-level reference model. Honours TX_CSUM_FIX_EN when defined.
module tb_tx_tos_marker;

  logic         clk;
  logic         rst;
  logic [255:0] s_tdata;
  logic         s_tvalid;
  logic         s_tlast;
  logic         s_tready;
  logic [255:0] m_tdata;
  logic         m_tvalid;
  logic         m_tlast;
  logic         m_tready;
  logic         mark_en;
  logic [31:0]  tx_count;
  logic [31:0]  tx_pkt_count;

  tx_tos_marker dut (
    .clk          (clk),
    .rst          (rst),
    .s_tdata      (s_tdata),
    .s_tvalid     (s_tvalid),
    .s_tlast      (s_tlast),
    .s_tready     (s_tready),
    .m_tdata      (m_tdata),
    .m_tvalid     (m_tvalid),
    .m_tlast      (m_tlast),
    .m_tready     (m_tready),
    .mark_en      (mark_en),
    .tx_count     (tx_count),
    .tx_pkt_count (tx_pkt_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef TX_CSUM_FIX_EN
  localparam logic [15:0] CS_B861_OUT = 16'hB839;
  localparam logic [15:0] CS_1234_OUT = 16'h121C;
`else
  localparam logic [15:0] CS_B861_OUT = 16'hB861;
  localparam logic [15:0] CS_1234_OUT = 16'h1234;
`endif

  typedef struct packed {
    logic [255:0] data;
    logic         last;
  } beat_t;

  typedef struct {
    logic [15:0] et;
    logic [7:0]  b14;
    logic [7:0]  tos;
    logic [15:0] cs;
    int          men;
    logic [7:0]  e_tos;
    logic [15:0] e_cs;
    int          e_mark;
  } vec_t;

  beat_t        exp_q[$];
  vec_t         vecs[7];
  int           n_cmp;
  int           n_bad;
  logic [31:0]  m_cnt;
  logic [31:0]  m_pkt;
  bit           m_first;
  bit           prev_stall;
  logic [255:0] held_data;
  logic         held_last;
  int           stall_left;
  bit           rnd_rdy;
  bit           rnd_gap;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [255:0] make_hdr(input logic [15:0] et, input logic [7:0] b14,
                                            input logic [7:0] tos, input logic [15:0] cs);
    logic [255:0] d;
    d = rnd256();
    d[103:96]  = et[15:8];
    d[111:104] = et[7:0];
    d[119:112] = b14;
    d[127:120] = tos;
    d[199:192] = cs[15:8];
    d[207:200] = cs[7:0];
    return d;
  endfunction

  // Reference: what a beat must look like on the output given its packet position.
  function automatic logic [255:0] ref_beat(input logic [255:0] d, input bit first,
                                            input logic men, output bit marked);
    logic [255:0] r;
`ifdef TX_CSUM_FIX_EN
    logic [31:0] hc;
    logic [31:0] mo;
    logic [31:0] mn;
    logic [31:0] s;
`endif
    r = d;
    marked = first && (men === 1'b1) && (d[103:96] == 8'h08) && (d[111:104] == 8'h00);
    if (marked) begin
      r[127:120] = 8'h28;
`ifdef TX_CSUM_FIX_EN
      hc = {16'h0, d[199:192], d[207:200]};
      mo = {16'h0, d[119:112], d[127:120]};
      mn = {16'h0, d[119:112], 8'h28};
      s  = (32'hFFFF ^ hc) + (32'hFFFF ^ mo) + mn;
      while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
      s = 32'hFFFF ^ s;
      r[199:192] = s[15:8];
      r[207:200] = s[7:0];
`endif
    end
    return r;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_cnt      = 0;
    m_pkt      = 0;
    m_first    = 1'b1;
    prev_stall = 1'b0;
  endtask

  // One clock: check state at negedge, advance model for the coming edge, return after edge.
  task automatic cycle(output bit acc);
    bit    exp_rdy;
    bit    mk;
    beat_t b;
    @(negedge clk);
    check("m_tvalid", 256'(m_tvalid), 256'(exp_q.size() != 0));
    check("tx_count", 256'(tx_count), 256'(m_cnt));
    check("tx_pkt_count", 256'(tx_pkt_count), 256'(m_pkt));
    exp_rdy = (exp_q.size() == 0) || m_tready;
    check("s_tready", 256'(s_tready), 256'(exp_rdy));
    if (prev_stall) begin
      check("stall_hold_data", m_tdata, held_data);
      check("stall_hold_last", 256'(m_tlast), 256'(held_last));
    end
    prev_stall = (exp_q.size() != 0) && !m_tready;
    held_data  = m_tdata;
    held_last  = m_tlast;
    if (exp_q.size() != 0 && m_tready) begin
      b = exp_q.pop_front();
      check("out_data", m_tdata, b.data);
      check("out_last", 256'(m_tlast), 256'(b.last));
    end
    acc = s_tvalid && exp_rdy;
    if (acc) begin
      b.data = ref_beat(s_tdata, m_first, mark_en, mk);
      b.last = s_tlast;
      exp_q.push_back(b);
      if (m_first) m_pkt = m_pkt + 1;
      if (mk) m_cnt = m_cnt + 1;
      m_first = s_tlast;
    end
    @(posedge clk);
    #1;
    if (stall_left > 0) begin
      m_tready = 1'b0;
      stall_left--;
    end else begin
      m_tready = rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  endtask

  task automatic send_beat(input logic [255:0] d, input logic last, input int men_mode);
    bit acc;
    int guard;
    if (rnd_gap && $urandom_range(0, 3) == 0) begin
      s_tvalid = 1'b0;
      cycle(acc);
    end
    s_tdata  = d;
    s_tlast  = last;
    s_tvalid = 1'b1;
    mark_en  = (men_mode == 2) ? 1'($urandom_range(0, 1)) : 1'(men_mode);
    acc   = 1'b0;
    guard = 0;
    while (!acc && guard < 200) begin
      cycle(acc);
      guard++;
    end
    if (!acc) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: no accept after %0d cycles, required within 200", guard);
    end
    s_tvalid = 1'b0;
  endtask

  task automatic send_pkt(input int nb, input logic [15:0] et, input logic [7:0] b14,
                          input logic [7:0] tos, input logic [15:0] cs, input int men_mode);
    for (int i = 0; i < nb; i++) begin
      send_beat((i == 0) ? make_hdr(et, b14, tos, cs) : rnd256(), 1'(i == nb - 1), men_mode);
    end
  endtask

  task automatic drain();
    bit acc;
    int guard;
    s_tvalid = 1'b0;
    guard = 0;
    while ((exp_q.size() != 0 || stall_left > 0) && guard < 100) begin
      cycle(acc);
      guard++;
    end
    check("drain_empty", 256'(exp_q.size()), 256'(0));
  endtask

  task automatic do_reset();
    s_tvalid = 1'b0;
    rst = 1'b1;
    #1;
    model_reset();
    #10;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  logic [255:0] d0;
  logic [255:0] d1;
  logic [31:0]  cnt_before;

  initial begin
    n_cmp = 0; n_bad = 0;
    stall_left = 0; rnd_rdy = 1'b0; rnd_gap = 1'b0;
    s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0; mark_en = 1'b0; m_tready = 1'b1;
    model_reset();

    vecs[0] = '{16'h0800, 8'h45, 8'h00, 16'hB861, 1, 8'h28, CS_B861_OUT, 1};
    vecs[1] = '{16'h0800, 8'h45, 8'h10, 16'h1234, 1, 8'h28, CS_1234_OUT, 1};
    vecs[2] = '{16'h0800, 8'h45, 8'h00, 16'hB861, 0, 8'h00, 16'hB861,    0};
    vecs[3] = '{16'h86DD, 8'h45, 8'h00, 16'hB861, 1, 8'h00, 16'hB861,    0};
    vecs[4] = '{16'h0008, 8'h45, 8'h00, 16'hB861, 1, 8'h00, 16'hB861,    0};
    vecs[5] = '{16'h0801, 8'h45, 8'h00, 16'hB861, 1, 8'h00, 16'hB861,    0};
    vecs[6] = '{16'h0800, 8'h45, 8'h28, 16'h4444, 1, 8'h28, 16'h4444,    1};

    // Power-on reset values
    rst = 1'b1;
    #7;
    check("rst_m_tvalid", 256'(m_tvalid), 256'(0));
    check("rst_m_tdata", m_tdata, 256'(0));
    check("rst_m_tlast", 256'(m_tlast), 256'(0));
    check("rst_tx_count", 256'(tx_count), 256'(0));
    check("rst_tx_pkt_count", 256'(tx_pkt_count), 256'(0));
    check("rst_s_tready", 256'(s_tready), 256'(1));
    #5;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Two-beat marked IPv4 packet
    d0 = make_hdr(16'h0800, 8'h45, 8'h00, 16'hB861);
    d1 = rnd256();
    send_beat(d0, 1'b0, 1);
    check("p1_b0_valid", 256'(m_tvalid), 256'(1));
    check("p1_b0_tos", 256'(m_tdata[127:120]), 256'(8'h28));
    send_beat(d1, 1'b1, 1);
    check("p1_b1_exact", m_tdata, d1);
    check("p1_b1_last", 256'(m_tlast), 256'(1));
    drain();
    check("p1_tx_count", 256'(tx_count), 256'(1));
    check("p1_tx_pkt_count", 256'(tx_pkt_count), 256'(1));

    // IPv6 marked-enable and IPv4 mark-disabled both pass untouched
    do_reset();
    send_pkt(2, 16'h86DD, 8'h60, 8'h00, 16'hB861, 1);
    send_pkt(2, 16'h0800, 8'h45, 8'h00, 16'hB861, 0);
    drain();
    check("p2_tx_count", 256'(tx_count), 256'(0));
    check("p2_tx_pkt_count", 256'(tx_pkt_count), 256'(2));

    // Backpressure: output stalls 5 cycles while a 4-beat marked packet streams
    do_reset();
    m_tready = 1'b0;
    stall_left = 5;
    send_pkt(4, 16'h0800, 8'h45, 8'h00, 16'hB861, 1);
    drain();
    check("bp_tx_count", 256'(tx_count), 256'(1));
    check("bp_tx_pkt_count", 256'(tx_pkt_count), 256'(1));

    // Ten back-to-back single-beat packets, mark_en toggling from 1
    do_reset();
    for (int i = 0; i < 10; i++) send_pkt(1, 16'h0800, 8'h45, 8'h00, 16'hB861, (i % 2 == 0) ? 1 : 0);
    drain();
    check("b2b_tx_count", 256'(tx_count), 256'(5));
    check("b2b_tx_pkt_count", 256'(tx_pkt_count), 256'(10));

    // Reset in the middle of a 3-beat packet
    send_beat(make_hdr(16'h0800, 8'h45, 8'h00, 16'hB861), 1'b0, 1);
    send_beat(rnd256(), 1'b0, 1);
    rst = 1'b1;
    #1;
    check("midrst_tx_count", 256'(tx_count), 256'(0));
    check("midrst_tx_pkt_count", 256'(tx_pkt_count), 256'(0));
    check("midrst_m_tvalid", 256'(m_tvalid), 256'(0));
    model_reset();
    #10;
    rst = 1'b0;
    @(posedge clk);
    #1;
    send_pkt(1, 16'h0800, 8'h45, 8'h00, 16'hB861, 1);
    check("postrst_tos", 256'(m_tdata[127:120]), 256'(8'h28));
    drain();
    check("postrst_tx_count", 256'(tx_count), 256'(1));

    // Directed single-beat header table
    for (int v = 0; v < 7; v++) begin
      cnt_before = tx_count;
      send_pkt(1, vecs[v].et, vecs[v].b14, vecs[v].tos, vecs[v].cs, vecs[v].men);
      check($sformatf("vec%0d_tos", v), 256'(m_tdata[127:120]), 256'(vecs[v].e_tos));
      check($sformatf("vec%0d_csum", v), 256'({m_tdata[199:192], m_tdata[207:200]}),
            256'(vecs[v].e_cs));
      drain();
      check($sformatf("vec%0d_mark", v), 256'(tx_count - cnt_before), 256'(vecs[v].e_mark));
    end

    // Randomized traffic with gaps, backpressure and mid-packet mark_en changes
    rnd_rdy = 1'b1;
    rnd_gap = 1'b1;
    for (int p = 0; p < 300; p++) begin
      send_pkt($urandom_range(1, 4), ($urandom_range(0, 3) != 0) ? 16'h0800 : 16'h86DD,
               8'($urandom), 8'($urandom), 16'($urandom), 2);
    end
    drain();
    rnd_rdy = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
